bus_arbiter: RTL and testbench

Round-robin arbiter that shares one slave bus port (memory or peripheral window) among N masters in the bare system. It grants exactly one requester at a time and holds the grant until the slave signals completion, the requester withdraws, or a watchdog timeout expires. SEL drives the select input of the shared address/data multiplexers (mux2/mux4/mux8); GNT drives each master's enable.

---
 rtl/bus_arbiter.sv | 107 ++++++++++
 tb/tb_bus_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port among N masters.
// A grant is held until DONE, the owner drops REQ, or the watchdog expires.
module bus_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 255,
    localparam int SW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [N-1:0]  REQ,
    input  logic          DONE,
    output logic [N-1:0]  GNT,
    output logic [SW-1:0] SEL,
    output logic          BUSY,
    output logic          TIMEOUT_ERR,
    output logic [SW-1:0] ERR_ID
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    state_t        state_q;
    logic [N-1:0]  gnt_q;
    logic [SW-1:0] sel_q;
    logic          busy_q;
    logic          terr_q;
    logic [SW-1:0] err_id_q;
    logic [SW-1:0] last_q;
    logic [CW-1:0] cnt_q;

    logic          win_vld_d;
    logic [SW-1:0] win_idx_d;
    logic          rel_d;
    logic          tmo_d;

    // Scan from the far end toward LAST+1 so the nearest requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last_q) + i) % N;
            if (REQ[idx]) begin
                win_vld_d = 1'b1;
                win_idx_d = SW'(idx);
            end
        end
    end

    // DONE and abandon outrank the watchdog, so a DONE on the last cycle is clean.
    always_comb begin
        tmo_d = !DONE && REQ[sel_q] && (cnt_q == CNT_LAST);
        rel_d = DONE || !REQ[sel_q] || (cnt_q == CNT_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            terr_q   <= 1'b0;
            err_id_q <= '0;
            last_q   <= SW'(N - 1);
            cnt_q    <= '0;
        end else begin
            terr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (win_vld_d) begin
                        gnt_q   <= ONE_HOT0 << win_idx_d;
                        sel_q   <= win_idx_d;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (rel_d) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        last_q  <= sel_q;
                        state_q <= IDLE;
                        if (tmo_d) begin
                            terr_q   <= 1'b1;
                            err_id_q <= sel_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign GNT         = gnt_q;
    assign SEL         = sel_q;
    assign BUSY        = busy_q;
    assign TIMEOUT_ERR = terr_q;
    assign ERR_ID      = err_id_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (N=4, TIMEOUT=8): directed timing checks plus a
// scoreboard of expected grant winners checked whenever a new grant appears.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam int SW = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic [N-1:0]  REQ;
    logic          DONE;
    logic [N-1:0]  GNT;
    logic [SW-1:0] SEL;
    logic          BUSY;
    logic          TIMEOUT_ERR;
    logic [SW-1:0] ERR_ID;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic [N-1:0] gnt_prev = '0;

    bus_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .DONE(DONE),
        .GNT(GNT), .SEL(SEL), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR), .ERR_ID(ERR_ID)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard side: every fresh grant must match the next queued winner.
    always @(negedge CLK) begin
        if (!RESET) begin
            chk("onehot", 32'($countones(GNT) <= 1), 32'd1);
            if (GNT != '0 && gnt_prev == '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", 32'(GNT), 32'd0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("sb_sel", 32'(SEL), 32'(e));
                    chk("sb_gnt", 32'(GNT), 32'(1 << e));
                end
            end
        end
        gnt_prev = GNT;
    end

    initial begin
        RESET = 1'b1; REQ = '0; DONE = 1'b0;
        tick(); tick();
        RESET = 1'b0;
        chk("rst_gnt", 32'(GNT), 0);
        chk("rst_sel", 32'(SEL), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_terr", 32'(TIMEOUT_ERR), 0);
        chk("rst_errid", 32'(ERR_ID), 0);

        // Single requester, DONE three cycles into the grant.
        REQ = 4'b0100; exp_q.push_back(2);
        tick();
        chk("t1_gnt", 32'(GNT), 32'h4);
        chk("t1_sel", 32'(SEL), 2);
        chk("t1_busy", 32'(BUSY), 1);
        tick(); tick();
        DONE = 1'b1;
        tick();
        DONE = 1'b0; REQ = '0;
        chk("t1_rel_gnt", 32'(GNT), 0);
        chk("t1_rel_busy", 32'(BUSY), 0);
        chk("t1_terr", 32'(TIMEOUT_ERR), 0);
        chk("t1_sel_hold", 32'(SEL), 2);
        tick();

        // Fresh reset, then full contention: order 0,1,2,3,0 with dead cycles.
        RESET = 1'b1; tick(); RESET = 1'b0;
        REQ = 4'b1111;
        for (int k = 0; k < 5; k++) exp_q.push_back(k % N);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_gnt", 32'(GNT), 32'(1 << (k % N)));
            tick();
            DONE = 1'b1;
            tick();
            DONE = 1'b0;
            chk("rr_dead", 32'(GNT), 0);
            chk("rr_terr", 32'(TIMEOUT_ERR), 0);
        end
        REQ = '0;
        tick();

        // Watchdog: grant lasts exactly TO cycles, then a one-cycle error pulse.
        REQ = 4'b0010; exp_q.push_back(1);
        tick();
        for (int c = 0; c < TO; c++) begin
            chk("to_hold", 32'(GNT), 32'h2);
            chk("to_noerr", 32'(TIMEOUT_ERR), 0);
            tick();
        end
        chk("to_rel_gnt", 32'(GNT), 0);
        chk("to_terr", 32'(TIMEOUT_ERR), 1);
        chk("to_errid", 32'(ERR_ID), 1);
        exp_q.push_back(1);
        tick();
        chk("to_regrant", 32'(GNT), 32'h2);
        chk("to_pulse_end", 32'(TIMEOUT_ERR), 0);
        REQ = '0;
        tick();
        chk("abandon_gnt", 32'(GNT), 0);
        chk("abandon_terr", 32'(TIMEOUT_ERR), 0);
        chk("errid_held", 32'(ERR_ID), 1);

        // DONE lands on the last allowed cycle: clean release.
        REQ = 4'b0001; exp_q.push_back(0);
        tick();
        for (int c = 1; c < TO; c++) tick();
        chk("edge_still_gnt", 32'(GNT), 32'h1);
        DONE = 1'b1;
        tick();
        DONE = 1'b0; REQ = '0;
        chk("edge_rel", 32'(GNT), 0);
        chk("edge_terr", 32'(TIMEOUT_ERR), 0);
        tick();
        chk("edge_terr2", 32'(TIMEOUT_ERR), 0);

        // Master 3 abandons while master 0 waits.
        REQ = 4'b1000; exp_q.push_back(3);
        tick();
        chk("ab_gnt3", 32'(GNT), 32'h8);
        REQ = 4'b1001;
        tick();
        chk("ab_hold3", 32'(GNT), 32'h8);
        REQ = 4'b0001;
        tick();
        chk("ab_dead", 32'(GNT), 0);
        exp_q.push_back(0);
        tick();
        chk("ab_gnt0", 32'(GNT), 32'h1);
        chk("ab_sel0", 32'(SEL), 0);
        REQ = '0;
        tick();

        // Reset in the middle of a grant.
        REQ = 4'b1111; exp_q.push_back(1);
        tick();
        chk("rm_gnt1", 32'(GNT), 32'h2);
        tick();
        RESET = 1'b1;
        tick();
        chk("rm_gnt", 32'(GNT), 0);
        chk("rm_sel", 32'(SEL), 0);
        chk("rm_busy", 32'(BUSY), 0);
        chk("rm_terr", 32'(TIMEOUT_ERR), 0);
        chk("rm_errid", 32'(ERR_ID), 0);
        RESET = 1'b0; exp_q.push_back(0);
        tick();
        chk("rm_first", 32'(GNT), 32'h1);
        REQ = '0; DONE = 1'b1;
        tick();
        DONE = 1'b0;
        tick(); tick();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
